// File: rtl/unpack_pbits.sv
// Receive-side p-bit frame unpacker: reassembles FRAME_COUNT beats into one vector,
// publishes it atomically, and counts/recovers from framing violations.
module unpack_pbits #(
    parameter int DATA_WIDTH      = 256,
    parameter int TOTAL_NUM_PBITS = 1024,
    parameter int ERR_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      m_axis_rx_tdata,
    input  logic                       m_axis_rx_tvalid,
    input  logic                       m_axis_rx_tlast,
    output logic [TOTAL_NUM_PBITS-1:0] pbits,
    output logic                       pbits_valid,
    output logic                       frame_err,
    output logic [ERR_CNT_WIDTH-1:0]   err_count
);
    localparam int FRAME_COUNT = TOTAL_NUM_PBITS / DATA_WIDTH;
    localparam int IDX_W       = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_COUNT - 1);

    typedef enum logic {SYNC, ACCEPT} state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [TOTAL_NUM_PBITS-1:0] shadow;
    logic [TOTAL_NUM_PBITS-1:0] assembled;

    // Top slice of the shadow is never stored; the live final beat takes its place.
    always_comb begin
        assembled = shadow;
        assembled[(FRAME_COUNT-1)*DATA_WIDTH +: DATA_WIDTH] = m_axis_rx_tdata;
    end

    always_ff @(posedge clk) begin
        if (m_axis_rx_tvalid && state == ACCEPT && !m_axis_rx_tlast && idx != LAST_IDX) begin
            for (int unsigned k = 0; k < FRAME_COUNT - 1; k++) begin
                if (idx == IDX_W'(k))
                    shadow[k*DATA_WIDTH +: DATA_WIDTH] <= m_axis_rx_tdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC;
            idx         <= '0;
            pbits       <= '0;
            pbits_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            pbits_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (m_axis_rx_tvalid) begin
                case (state)
                    SYNC: begin
                        if (m_axis_rx_tlast) begin
                            state <= ACCEPT;
                            idx   <= '0;
                        end
                    end
                    ACCEPT: begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (m_axis_rx_tlast) begin
                                pbits       <= assembled;
                                pbits_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                if (err_count != '1)
                                    err_count <= err_count + 1'b1;
                                state <= SYNC;
                            end
                        end else if (m_axis_rx_tlast) begin
                            frame_err <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + 1'b1;
                            idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: begin
                        state <= SYNC;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_unpack_pbits.sv
// Scoreboard bench for unpack_pbits: expected vectors are queued as stimulus is driven
// and compared when pbits_valid pulses; a second instance exercises error-count saturation.
module tb_unpack_pbits;
    localparam int DW = 256;
    localparam int TW = 1024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   tdata = '0;
    logic            tvalid = 1'b0;
    logic            tlast = 1'b0;
    logic [TW-1:0]   pbits, pbits_s;
    logic            pbits_valid, pbits_valid_s;
    logic            frame_err, frame_err_s;
    logic [15:0]     err_count;
    logic [1:0]      err_count_s;

    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int fcnt = 0;
    int fcnt_s = 0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] last_pb = '0;

    always #5 clk = ~clk;

    unpack_pbits #(.DATA_WIDTH(DW), .TOTAL_NUM_PBITS(TW), .ERR_CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_axis_rx_tdata(tdata), .m_axis_rx_tvalid(tvalid), .m_axis_rx_tlast(tlast),
        .pbits(pbits), .pbits_valid(pbits_valid), .frame_err(frame_err), .err_count(err_count)
    );

    unpack_pbits #(.DATA_WIDTH(DW), .TOTAL_NUM_PBITS(TW), .ERR_CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .m_axis_rx_tdata(tdata), .m_axis_rx_tvalid(tvalid), .m_axis_rx_tlast(tlast),
        .pbits(pbits_s), .pbits_valid(pbits_valid_s), .frame_err(frame_err_s), .err_count(err_count_s)
    );

    // Output monitor: pops the scoreboard on each valid pulse and checks pbits holds otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_pb = '0;
        end else begin
            total++;
            if (pbits_valid) begin
                vcnt++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid pbits=%h required=no pulse", pbits[63:0]);
                end else begin
                    logic [TW-1:0] e;
                    e = exp_q.pop_front();
                    if (pbits !== e) begin
                        bad++;
                        $display("FAIL vector low64=%h required=%h high64=%h required=%h",
                                 pbits[63:0], e[63:0], pbits[TW-1 -: 64], e[TW-1 -: 64]);
                    end
                end
                last_pb = pbits;
            end else if (pbits !== last_pb) begin
                bad++;
                $display("FAIL hold pbits low64=%h required=%h", pbits[63:0], last_pb[63:0]);
            end
            if (frame_err) fcnt++;
            if (frame_err_s) fcnt_s++;
        end
    end

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic beat(input logic [DW-1:0] d, input logic l);
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
            tdata  = rnd();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        tvalid = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_vec(input logic gaps);
        logic [TW-1:0] v;
        for (int k = 0; k < TW / DW; k++) begin
            v[k*DW +: DW] = rnd();
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            if (k == TW / DW - 1) exp_q.push_back(v);
            beat(v[k*DW +: DW], k == TW / DW - 1);
        end
    endtask

    task automatic drain_check(input string name, input int exp_v, input int v0,
                               input int exp_f, input int f0, input logic [15:0] exp_e);
        idle(3);
        total++;
        if (vcnt - v0 !== exp_v) begin
            bad++;
            $display("FAIL %s_valid_pulses got=%0d required=%0d", name, vcnt - v0, exp_v);
        end
        total++;
        if (fcnt - f0 !== exp_f) begin
            bad++;
            $display("FAIL %s_frame_err_pulses got=%0d required=%0d", name, fcnt - f0, exp_f);
        end
        total++;
        if (err_count !== exp_e) begin
            bad++;
            $display("FAIL %s_err_count got=%0d required=%0d", name, err_count, exp_e);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (pbits !== '0 || pbits_valid !== 1'b0 || frame_err !== 1'b0 || err_count !== '0) begin
            bad++;
            $display("FAIL reset_outputs pbits_lo=%h valid=%b ferr=%b errs=%0d required=0",
                     pbits[63:0], pbits_valid, frame_err, err_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_vector();
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        do_reset();
        beat(rnd(), 1'b1);
        send_vec(1'b0);
        @(negedge clk);
        tvalid = 1'b0;
        total++;
        if (pbits_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_latency valid=%b required=1", pbits_valid);
        end
        @(negedge clk);
        total++;
        if (pbits_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_pulse_width valid=%b required=0", pbits_valid);
        end
        drain_check("first", 1, v0, 0, f0, 16'd0);
    endtask

    task automatic test_gaps();
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        for (int i = 0; i < 3; i++) send_vec(1'b1);
        drain_check("gaps", 3, v0, 0, f0, 16'd0);
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        for (int i = 0; i < 4; i++) send_vec(1'b0);
        drain_check("b2b", 4, v0, 0, f0, 16'd0);
    endtask

    task automatic test_early_tlast();
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        do_reset();
        beat(rnd(), 1'b1);
        beat(rnd(), 1'b0);
        beat(rnd(), 1'b1);
        send_vec(1'b0);
        drain_check("early", 1, v0, 1, f0, 16'd1);
    endtask

    task automatic test_missing_tlast();
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        do_reset();
        beat(rnd(), 1'b1);
        for (int i = 0; i < 4; i++) beat(rnd(), 1'b0);
        idle(1);
        total++;
        if (frame_err !== 1'b1) begin
            bad++;
            $display("FAIL missing_err_timing frame_err=%b required=1", frame_err);
        end
        beat(rnd(), 1'b1);
        send_vec(1'b0);
        drain_check("missing", 1, v0, 1, f0, 16'd1);
    endtask

    task automatic test_reset_mid_vector();
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        beat(rnd(), 1'b0);
        beat(rnd(), 1'b0);
        @(negedge clk);
        tvalid = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (pbits !== '0 || pbits_valid !== 1'b0 || frame_err !== 1'b0 || err_count !== '0) begin
                bad++;
                $display("FAIL midreset_outputs pbits_lo=%h valid=%b ferr=%b errs=%0d required=0",
                         pbits[63:0], pbits_valid, frame_err, err_count);
            end
        end
        rst_n = 1'b1;
        beat(rnd(), 1'b1);
        send_vec(1'b0);
        drain_check("midreset", 1, v0, 0, f0, 16'd0);
    endtask

    task automatic test_saturation();
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        int f0;
        do_reset();
        f0 = fcnt_s;
        beat(rnd(), 1'b1);
        for (int i = 0; i < 5; i++) begin
            beat(rnd(), 1'b1);
            idle(1);
            total++;
            if (err_count_s !== seq[i] || frame_err_s !== 1'b1) begin
                bad++;
                $display("FAIL sat_step%0d err_count=%0d frame_err=%b required=%0d/1",
                         i, err_count_s, frame_err_s, seq[i]);
            end
        end
        idle(2);
        total++;
        if (fcnt_s - f0 !== 5) begin
            bad++;
            $display("FAIL sat_pulses got=%0d required=5", fcnt_s - f0);
        end
        total++;
        if (err_count !== 16'd5) begin
            bad++;
            $display("FAIL sat_wide_count got=%0d required=5", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_first_vector();
        test_gaps();
        test_back_to_back();
        test_early_tlast();
        test_missing_tlast();
        test_reset_mid_vector();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
